buff_manager: RTL and testbench

BUFF_MANAGER -- requirements
Module: buff_manager

---
 rtl/buff_pkg.sv | 40 ++++
 rtl/buff_player.sv | 118 +++++++++++
 rtl/buff_manager.sv | 74 +++++++
 tb/tb_buff_manager.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buff_pkg.sv
// Shared types, reset values and saturating helpers for the power-up buff manager.
package buff_pkg;

  typedef enum logic [1:0] {
    STAT_STEP     = 2'd0,
    STAT_DELAY    = 2'd1,
    STAT_COOLDOWN = 2'd2,
    STAT_SIZE     = 2'd3
  } stat_e;

  typedef enum logic {
    NORMAL = 1'b0,
    CURSED = 1'b1
  } curse_state_e;

  typedef struct packed {
    logic [9:0] step;
    logic [9:0] delay;
    logic [9:0] cooldown;
    logic [1:0] size;
  } stats_t;

  localparam logic [9:0] RST_STEP     = 10'd3;
  localparam logic [1:0] RST_SIZE     = 2'b01;
  localparam logic [9:0] RST_DELAY    = 10'h030;
  localparam logic [9:0] RST_COOLDOWN = 10'h018;

  function automatic logic [9:0] sat_add(input logic [9:0] v, input logic [9:0] d,
                                         input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, v} + {1'b0, d};
    return (sum > {1'b0, lim}) ? lim : sum[9:0];
  endfunction

  function automatic logic [9:0] sat_sub(input logic [9:0] v, input logic [9:0] d,
                                         input logic [9:0] lim);
    return ({1'b0, v} < ({1'b0, lim} + {1'b0, d})) ? lim : v - d;
  endfunction

endpackage

// File: rtl/buff_player.sv
// One player's stats, curse FSM and curse timer.
module buff_player
  import buff_pkg::*;
#(
  parameter int unsigned PLAYER_IDX   = 0,
  parameter logic [3:0]  ITEM_TAG     = 4'h9,
  parameter logic [9:0]  STEP_MIN     = 10'd1,
  parameter logic [9:0]  STEP_MAX     = 10'd5,
  parameter logic [9:0]  TIME_MIN     = 10'h010,
  parameter logic [9:0]  TIME_MAX     = 10'h050,
  parameter logic [9:0]  TIME_INC     = 10'h008,
  parameter logic [15:0] CURSE_FRAMES = 16'd600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [7:0] id,
  input  logic [3:0] r,
  output logic       we,
  output logic [9:0] step,
  output logic [1:0] size,
  output logic [9:0] delay,
  output logic [9:0] cooldown,
  output logic       cursed
);

  localparam stats_t RST_STATS = '{step: RST_STEP, delay: RST_DELAY,
                                   cooldown: RST_COOLDOWN, size: RST_SIZE};

  curse_state_e state_q, state_d;
  stats_t       stats_q, stats_d, debuffed;
  logic [15:0]  timer_q, timer_d;
  stat_e        cstat_q, cstat_d, stat;
  logic         applied_q, applied_d;
  logic         we_q, we_d;
  logic         pickup, debuff;

  // buff=1 moves a stat in the player's favour, buff=0 against it
  function automatic stats_t adjust(input stats_t s, input stat_e which, input logic buff);
    stats_t o;
    o = s;
    case (which)
      STAT_STEP:     o.step = buff ? sat_add(s.step, 10'd1, STEP_MAX)
                                   : sat_sub(s.step, 10'd1, STEP_MIN);
      STAT_DELAY:    o.delay = buff ? sat_sub(s.delay, TIME_INC, TIME_MIN)
                                    : sat_add(s.delay, TIME_INC, TIME_MAX);
      STAT_COOLDOWN: o.cooldown = buff ? sat_sub(s.cooldown, TIME_INC, TIME_MIN)
                                       : sat_add(s.cooldown, TIME_INC, TIME_MAX);
      STAT_SIZE:     o.size = buff ? ((s.size == 2'd3) ? 2'd3 : s.size + 2'd1)
                                   : ((s.size == 2'd0) ? 2'd0 : s.size - 2'd1);
    endcase
    return o;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NORMAL;
      stats_q   <= RST_STATS;
      timer_q   <= '0;
      cstat_q   <= STAT_STEP;
      applied_q <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      stats_q   <= stats_d;
      timer_q   <= timer_d;
      cstat_q   <= cstat_d;
      applied_q <= applied_d;
      we_q      <= we_d;
    end
  end

  // Expiry is resolved first so a same-tick pickup sees the restored stats.
  always_comb begin
    pickup    = frame_tick && (id == {ITEM_TAG, 4'(PLAYER_IDX)});
    stat      = stat_e'(r[3:2]);
    debuff    = r[1] & r[0];
    state_d   = state_q;
    stats_d   = stats_q;
    timer_d   = timer_q;
    cstat_d   = cstat_q;
    applied_d = applied_q;
    we_d      = pickup;
    debuffed  = stats_q;
    if (state_q == CURSED && frame_tick) begin
      if (timer_q == '0) begin
        if (applied_q) stats_d = adjust(stats_q, cstat_q, 1'b1);
        state_d = NORMAL;
      end else begin
        timer_d = timer_q - 16'd1;
      end
    end
    if (pickup) begin
      if (!debuff) begin
        stats_d = adjust(stats_d, stat, 1'b1);
      end else if (state_d == CURSED) begin
        timer_d = CURSE_FRAMES - 16'd1;
      end else begin
        debuffed  = adjust(stats_d, stat, 1'b0);
        applied_d = (debuffed != stats_d);
        stats_d   = debuffed;
        cstat_d   = stat;
        timer_d   = CURSE_FRAMES - 16'd1;
        state_d   = CURSED;
      end
    end
  end

  always_comb begin
    we       = we_q;
    step     = stats_q.step;
    size     = stats_q.size;
    delay    = stats_q.delay;
    cooldown = stats_q.cooldown;
    cursed   = (state_q == CURSED);
  end

endmodule

// File: rtl/buff_manager.sv
// Frame-edge detect and random-nibble register shared by per-player buff units.
module buff_manager
  import buff_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter logic [3:0]  ITEM_TAG     = 4'h9,
  parameter logic [9:0]  STEP_MIN     = 10'd1,
  parameter logic [9:0]  STEP_MAX     = 10'd5,
  parameter logic [9:0]  TIME_MIN     = 10'h010,
  parameter logic [9:0]  TIME_MAX     = 10'h050,
  parameter logic [9:0]  TIME_INC     = 10'h008,
  parameter logic [15:0] CURSE_FRAMES = 16'd600
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_clk,
  input  logic [NUM_PLAYERS-1:0][7:0] id,
  input  logic [3:0]                  randhex,
  output logic [NUM_PLAYERS-1:0]      WE,
  output logic [NUM_PLAYERS-1:0][9:0] step,
  output logic [NUM_PLAYERS-1:0][1:0] size,
  output logic [NUM_PLAYERS-1:0][9:0] delay,
  output logic [NUM_PLAYERS-1:0][9:0] cooldown,
  output logic [NUM_PLAYERS-1:0]      cursed
);

  logic       frame_clk_q, frame_clk_d;
  logic       frame_tick_q, frame_tick_d;
  logic [3:0] randh_q, randh_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      randh_q      <= '0;
    end else begin
      frame_clk_q  <= frame_clk_d;
      frame_tick_q <= frame_tick_d;
      randh_q      <= randh_d;
    end
  end

  always_comb begin
    frame_clk_d  = frame_clk;
    frame_tick_d = frame_clk & ~frame_clk_q;
    randh_d      = randhex;
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    buff_player #(
      .PLAYER_IDX  (p),
      .ITEM_TAG    (ITEM_TAG),
      .STEP_MIN    (STEP_MIN),
      .STEP_MAX    (STEP_MAX),
      .TIME_MIN    (TIME_MIN),
      .TIME_MAX    (TIME_MAX),
      .TIME_INC    (TIME_INC),
      .CURSE_FRAMES(CURSE_FRAMES)
    ) u_player (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .frame_tick(frame_tick_q),
      .id        (id[p]),
      .r         (randh_q ^ 4'(p)),
      .we        (WE[p]),
      .step      (step[p]),
      .size      (size[p]),
      .delay     (delay[p]),
      .cooldown  (cooldown[p]),
      .cursed    (cursed[p])
    );
  end

endmodule

// File: tb/tb_buff_manager.sv
// Directed bench for buff_manager: behavioural model compared every cycle plus literal checks.
module tb_buff_manager;

  localparam int N = 2;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_clk;
  logic [N-1:0][7:0] id;
  logic [3:0]        randhex;
  logic [N-1:0]      WE;
  logic [N-1:0][9:0] step;
  logic [N-1:0][1:0] size;
  logic [N-1:0][9:0] delay;
  logic [N-1:0][9:0] cooldown;
  logic [N-1:0]      cursed;

  int checks = 0;
  int errors = 0;
  int we_cnt0 = 0;

  buff_manager #(
    .NUM_PLAYERS (N),
    .ITEM_TAG    (4'h9),
    .CURSE_FRAMES(16'd600)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .frame_clk(frame_clk),
    .id      (id),
    .randhex (randhex),
    .WE      (WE),
    .step    (step),
    .size    (size),
    .delay   (delay),
    .cooldown(cooldown),
    .cursed  (cursed)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: plain integers, clamped arithmetic.
  int m_step[N], m_size[N], m_delay[N], m_cool[N], m_timer[N], m_cstat[N];
  bit m_cursed[N], m_applied[N], m_we[N];
  bit m_fq, m_tick;
  logic [3:0] m_rand;

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // good=1 favours the player; returns whether the stat moved
  function automatic bit shift_stat(int p, int st, bit good);
    int old;
    case (st)
      0: begin old = m_step[p];  m_step[p]  = clamp(old + (good ? 1 : -1), 1, 5);      return m_step[p] != old;  end
      1: begin old = m_delay[p]; m_delay[p] = clamp(old + (good ? -8 : 8), 16, 80);    return m_delay[p] != old; end
      2: begin old = m_cool[p];  m_cool[p]  = clamp(old + (good ? -8 : 8), 16, 80);    return m_cool[p] != old;  end
      default: begin old = m_size[p]; m_size[p] = clamp(old + (good ? 1 : -1), 0, 3); return m_size[p] != old;  end
    endcase
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    logic [3:0] r;
    bit pk;
    if (!Reset_n) begin
      for (int p = 0; p < N; p++) begin
        m_step[p] = 3; m_size[p] = 1; m_delay[p] = 'h30; m_cool[p] = 'h18;
        m_timer[p] = 0; m_cstat[p] = 0; m_cursed[p] = 0; m_applied[p] = 0; m_we[p] = 0;
      end
      m_fq = 0; m_tick = 0; m_rand = '0;
    end else begin
      for (int p = 0; p < N; p++) begin
        if (m_tick && m_cursed[p]) begin
          if (m_timer[p] == 0) begin
            if (m_applied[p]) void'(shift_stat(p, m_cstat[p], 1'b1));
            m_cursed[p] = 0;
          end else begin
            m_timer[p] = m_timer[p] - 1;
          end
        end
        pk = m_tick && (id[p] == {4'h9, 4'(p)});
        m_we[p] = pk;
        if (pk) begin
          r = m_rand ^ 4'(p);
          if (!(r[1] && r[0])) begin
            void'(shift_stat(p, int'(r[3:2]), 1'b1));
          end else if (m_cursed[p]) begin
            m_timer[p] = 599;
          end else begin
            m_applied[p] = shift_stat(p, int'(r[3:2]), 1'b0);
            m_cstat[p]   = int'(r[3:2]);
            m_timer[p]   = 599;
            m_cursed[p]  = 1;
          end
        end
      end
      m_tick = frame_clk && !m_fq;
      m_fq   = frame_clk;
      m_rand = randhex;
    end
  end

  task automatic cmp(input string nm, input int p, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h", nm, p, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (WE[0]) we_cnt0++;
    for (int p = 0; p < N; p++) begin
      cmp("we",       p, int'(WE[p]),       int'(m_we[p]));
      cmp("step",     p, int'(step[p]),     m_step[p]);
      cmp("size",     p, int'(size[p]),     m_size[p]);
      cmp("delay",    p, int'(delay[p]),    m_delay[p]);
      cmp("cooldown", p, int'(cooldown[p]), m_cool[p]);
      cmp("cursed",   p, int'(cursed[p]),   int'(m_cursed[p]));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    repeat (2) cyc();
    frame_clk = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    id = '0;
    frame_clk = 1'b0;
    repeat (2) cyc();
    Reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    int exp_size[4];
    exp_size = '{2, 3, 3, 3};
    Reset_n = 1'b0; frame_clk = 1'b0; randhex = '0; id = '0;
    repeat (3) cyc();
    chk("rst_step",  int'(step[0]), 3);
    chk("rst_size",  int'(size[1]), 1);
    chk("rst_delay", int'(delay[0]), 'h30);
    chk("rst_cool",  int'(cooldown[1]), 'h18);
    chk("rst_we_cursed", int'({WE, cursed}), 0);
    Reset_n = 1'b1;
    cyc();

    // single step buff on player 0
    id[0] = 8'h90; randhex = 4'h0; we_cnt0 = 0;
    frame();
    chk("p0_step_buff", int'(step[0]), 4);
    chk("p0_we_once", we_cnt0, 1);
    chk("p1_untouched", int'(step[1]), 3);

    // step curse on player 1 and its expiry
    do_reset();
    id[1] = 8'h91; randhex = 4'h2;
    frame();
    chk("p1_cursed_step", int'(step[1]), 2);
    chk("p1_cursed", int'(cursed[1]), 1);
    id[1] = 8'h00;
    repeat (599) frame();
    chk("p1_still_cursed", int'(cursed[1]), 1);
    frame();
    chk("p1_restored_step", int'(step[1]), 3);
    chk("p1_uncursed", int'(cursed[1]), 0);

    // size saturation
    do_reset();
    id[0] = 8'h90; randhex = 4'hC; we_cnt0 = 0;
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("p0_size_seq", int'(size[0]), exp_size[i]);
    end
    chk("p0_we_four", we_cnt0, 4);

    // second debuff while cursed only reloads the timer
    do_reset();
    id[0] = 8'h90; randhex = 4'h3;
    frame();
    chk("p0_debuff1", int'(step[0]), 2);
    id[0] = 8'h00;
    repeat (99) frame();
    id[0] = 8'h90;
    frame();
    chk("p0_debuff2_nochange", int'(step[0]), 2);
    id[0] = 8'h00;
    repeat (599) frame();
    chk("p0_reload_cursed", int'(cursed[0]), 1);
    frame();
    chk("p0_reload_restore", int'(step[0]), 3);
    chk("p0_reload_uncursed", int'(cursed[0]), 0);

    // wrong id, no frame edge, long frame high
    do_reset();
    id[0] = 8'h91; randhex = 4'h0; we_cnt0 = 0;
    frame();
    chk("wrong_id_step", int'(step[0]), 3);
    id[0] = 8'h90;
    repeat (8) cyc();
    chk("no_edge_step", int'(step[0]), 3);
    chk("no_pickup_we", we_cnt0, 0);
    frame_clk = 1'b1;
    repeat (20) cyc();
    frame_clk = 1'b0;
    repeat (3) cyc();
    chk("long_frame_step", int'(step[0]), 4);
    chk("long_frame_we", we_cnt0, 1);

    // simultaneous pickups
    do_reset();
    id[0] = 8'h90; id[1] = 8'h91; randhex = 4'h0;
    frame();
    chk("sim_p0", int'(step[0]), 4);
    chk("sim_p1", int'(step[1]), 4);

    // delay floor
    do_reset();
    id[0] = 8'h90; randhex = 4'h4;
    repeat (6) frame();
    chk("delay_floor", int'(delay[0]), 'h10);

    // buffs during a cooldown curse, saturated restore
    do_reset();
    id[0] = 8'h90; randhex = 4'hB;
    frame();
    chk("cool_debuff", int'(cooldown[0]), 'h20);
    randhex = 4'h8;
    repeat (3) frame();
    chk("cool_buffed", int'(cooldown[0]), 'h10);
    id[0] = 8'h00;
    repeat (596) frame();
    chk("cool_cursed", int'(cursed[0]), 1);
    frame();
    chk("cool_uncursed", int'(cursed[0]), 0);
    chk("cool_restore_sat", int'(cooldown[0]), 'h10);

    // expiry and a new debuff on the same tick
    do_reset();
    id[0] = 8'h90; randhex = 4'h3;
    frame();
    id[0] = 8'h00;
    repeat (599) frame();
    id[0] = 8'h90;
    frame();
    chk("expire_redebuff_step", int'(step[0]), 2);
    chk("expire_redebuff_cursed", int'(cursed[0]), 1);

    // asynchronous reset mid-curse
    do_reset();
    id[1] = 8'h91; randhex = 4'h2;
    frame();
    chk("pre_rst_step", int'(step[1]), 2);
    id[1] = 8'h00;
    repeat (10) cyc();
    #1;
    Reset_n = 1'b0;
    #1;
    chk("async_step", int'(step[1]), 3);
    chk("async_cursed", int'(cursed[1]), 0);
    chk("async_delay", int'(delay[1]), 'h30);
    cyc();
    Reset_n = 1'b1;
    cyc();
    repeat (650) frame();
    chk("post_rst_step", int'(step[1]), 3);
    chk("post_rst_cursed", int'(cursed[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
